// File: rtl/out_bus_scheduler_if.sv
// Core-request / memory-beat bundle between the PE bus scheduler and its users.
interface out_bus_scheduler_if #(
  parameter int NUM_CORES      = 4,
  parameter int CORE_BIT_WIDTH = $clog2(NUM_CORES),
  parameter int ADDR_WIDTH     = 16,
  parameter int BURST_WIDTH    = 8
);
  logic [NUM_CORES-1:0]      w_req;
  logic                      w_mem_ack;
  logic [NUM_CORES-1:0]      r_grant;
  logic [CORE_BIT_WIDTH-1:0] r_sel;
  logic                      r_valid;
  logic                      r_rw;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [BURST_WIDTH-1:0]    r_burst;
  logic                      r_last;
  logic                      r_busy;

  modport master (
    input  w_req, w_mem_ack,
    output r_grant, r_sel, r_valid, r_rw, r_addr, r_burst, r_last, r_busy
  );
  modport slave (
    output w_req, w_mem_ack,
    input  r_grant, r_sel, r_valid, r_rw, r_addr, r_burst, r_last, r_busy
  );
endinterface

// File: rtl/out_bus_scheduler.sv
// Round-robin burst scheduler: one core at a time, alternating write/read bursts
// over a private wrapping address region per core, stallable by memory ack.
module out_bus_scheduler #(
  parameter int NUM_CORES      = 4,
  parameter int CORE_BIT_WIDTH = $clog2(NUM_CORES),
  parameter int ADDR_WIDTH     = 16,
  parameter int BURST_WIDTH    = 8,
  parameter int BURST_WRITE    = 8,
  parameter int BURST_READ     = 4
) (
  input logic                 w_clock,
  input logic                 w_reset,
  out_bus_scheduler_if.master bus
);
  localparam int LOW_W = ADDR_WIDTH - CORE_BIT_WIDTH;
  localparam logic [BURST_WIDTH-1:0] LEN_WR = BURST_WIDTH'(BURST_WRITE);
  localparam logic [BURST_WIDTH-1:0] LEN_RD = BURST_WIDTH'(BURST_READ);
  localparam logic [BURST_WIDTH-1:0] B_ONE  = BURST_WIDTH'(1);
  localparam logic [LOW_W-1:0]       L_ONE  = LOW_W'(1);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;

  state_t                         state;
  logic [CORE_BIT_WIDTH-1:0]      r_ptr;
  logic [NUM_CORES-1:0]           phase;
  logic [NUM_CORES-1:0][LOW_W-1:0] offset;
  logic [BURST_WIDTH-1:0]         cnt;

  logic                      arb_hit;
  logic [CORE_BIT_WIDTH-1:0] arb_sel;
  logic [LOW_W-1:0]          low_nxt;
  logic [BURST_WIDTH-1:0]    cnt_nxt;

  // Scan downward so the requester closest to r_ptr is the last (winning) write.
  always_comb begin
    arb_hit = 1'b0;
    arb_sel = r_ptr;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (bus.w_req[r_ptr + CORE_BIT_WIDTH'(i)]) begin
        arb_hit = 1'b1;
        arb_sel = r_ptr + CORE_BIT_WIDTH'(i);
      end
    end
  end

  assign low_nxt = bus.r_addr[LOW_W-1:0] + L_ONE;
  assign cnt_nxt = cnt + B_ONE;

  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      state       <= IDLE;
      r_ptr       <= '0;
      phase       <= '0;
      offset      <= '0;
      cnt         <= '0;
      bus.r_grant <= '0;
      bus.r_sel   <= '0;
      bus.r_valid <= 1'b0;
      bus.r_rw    <= 1'b0;
      bus.r_addr  <= '0;
      bus.r_burst <= '0;
      bus.r_last  <= 1'b0;
      bus.r_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arb_hit) begin
            state       <= GRANT;
            bus.r_grant <= NUM_CORES'(1) << arb_sel;
            bus.r_sel   <= arb_sel;
            bus.r_rw    <= phase[arb_sel];
            bus.r_burst <= phase[arb_sel] ? LEN_RD : LEN_WR;
            bus.r_addr  <= {arb_sel, offset[arb_sel]};
            cnt         <= '0;
            bus.r_busy  <= 1'b1;
          end else begin
            state      <= IDLE;
            bus.r_busy <= 1'b0;
          end
        end
        GRANT: begin
          state       <= XFER;
          bus.r_valid <= 1'b1;
          bus.r_last  <= (bus.r_burst == B_ONE);
        end
        XFER: begin
          if (bus.w_mem_ack) begin
            if (bus.r_last) begin
              // Remember where this core stops so its next burst continues there.
              state          <= DONE;
              bus.r_valid    <= 1'b0;
              bus.r_last     <= 1'b0;
              bus.r_grant    <= '0;
              offset[bus.r_sel] <= low_nxt;
              phase[bus.r_sel]  <= ~phase[bus.r_sel];
              r_ptr          <= bus.r_sel + CORE_BIT_WIDTH'(1);
            end else begin
              cnt        <= cnt_nxt;
              bus.r_addr <= {bus.r_addr[ADDR_WIDTH-1:LOW_W], low_nxt};
              bus.r_last <= (cnt_nxt == bus.r_burst - B_ONE);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_out_bus_scheduler.sv
// Bench for out_bus_scheduler: vector table, directed corner sequences and a
// burst-level reference model checked every cycle under random traffic.
`timescale 1ns/1ps
module tb_out_bus_scheduler;
  localparam int N    = 4;
  localparam int AW   = 16;
  localparam int LOW  = AW - 2;
  localparam int AW6  = 6;

  logic w_clock = 1'b0;
  logic w_reset = 1'b1;
  always #5 w_clock = ~w_clock;

  out_bus_scheduler_if #(.NUM_CORES(N), .ADDR_WIDTH(AW),  .BURST_WIDTH(8)) bus();
  out_bus_scheduler_if #(.NUM_CORES(N), .ADDR_WIDTH(AW6), .BURST_WIDTH(8)) bus6();

  out_bus_scheduler #(.NUM_CORES(N), .ADDR_WIDTH(AW)) u_dut (
    .w_clock(w_clock), .w_reset(w_reset), .bus(bus));
  out_bus_scheduler #(.NUM_CORES(N), .ADDR_WIDTH(AW6)) u_dut6 (
    .w_clock(w_clock), .w_reset(w_reset), .bus(bus6));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst-level reference: who owns the bus, how far its burst has got.
  int     m_ptr, m_core, m_rw, m_len, m_start, m_beats, m_addr;
  int     m_off[N];
  bit [N-1:0] m_phase;
  bit     m_active, m_started, m_done;

  function automatic int base(int c);
    return c << LOW;
  endfunction

  task automatic model_step(bit rst, bit [N-1:0] req, bit ack);
    if (rst) begin
      m_ptr = 0; m_phase = '0;
      for (int c = 0; c < N; c++) m_off[c] = 0;
      m_active = 0; m_started = 0; m_done = 0;
      m_core = 0; m_rw = 0; m_len = 0; m_start = 0; m_beats = 0; m_addr = 0;
    end else if (!m_active) begin
      m_done = 0;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (req[c]) begin
          m_active = 1; m_started = 0; m_core = c; m_rw = int'(m_phase[c]);
          m_len = m_rw ? 4 : 8; m_start = m_off[c]; m_beats = 0;
          m_addr = base(c) + m_start;
          break;
        end
      end
    end else if (!m_started) begin
      m_started = 1;
    end else if (ack) begin
      m_beats++;
      if (m_beats == m_len) begin
        m_off[m_core]   = (m_start + m_len) % (1 << LOW);
        m_phase[m_core] = ~m_phase[m_core];
        m_ptr = (m_core + 1) % N;
        m_active = 0; m_done = 1;
      end else begin
        m_addr = base(m_core) + (m_start + m_beats) % (1 << LOW);
      end
    end
  endtask

  task automatic model_check();
    check("mdl_grant", 32'(bus.r_grant), m_active ? (32'd1 << m_core) : 32'd0);
    check("mdl_sel",   32'(bus.r_sel),   32'(m_core));
    check("mdl_valid", 32'(bus.r_valid), 32'(m_active && m_started));
    check("mdl_rw",    32'(bus.r_rw),    32'(m_rw));
    check("mdl_addr",  32'(bus.r_addr),  32'(m_addr));
    check("mdl_burst", 32'(bus.r_burst), 32'(m_len));
    check("mdl_last",  32'(bus.r_last),  32'(m_active && m_started && (m_beats == m_len - 1)));
    check("mdl_busy",  32'(bus.r_busy),  32'(m_active || m_done));
  endtask

  task automatic cycle(bit rst, bit [N-1:0] req, bit ack);
    w_reset = rst; bus.w_req = req; bus.w_mem_ack = ack;
    @(posedge w_clock);
    model_step(rst, req, ack);
    #1;
    model_check();
  endtask

  typedef struct {
    bit rst; bit [3:0] req; bit ack;
    bit [3:0] grant; bit [1:0] sel; bit valid; bit rw;
    bit [15:0] addr; bit [7:0] burst; bit last; bit busy;
  } vec_t;

  function automatic vec_t mk(bit rst, bit [3:0] req, bit ack, bit [3:0] grant, bit [1:0] sel,
                              bit valid, bit rw, bit [15:0] addr, bit [7:0] burst, bit last, bit busy);
    vec_t v;
    v = '{rst, req, ack, grant, sel, valid, rw, addr, burst, last, busy};
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[$];
    bit [N-1:0] prev_g;
    int ngr, zeros, n2, last_idx, lo;
    bit seen, got;
    int acked[$];
    int q6[$];
    bit pat[7];

    bus.w_req = '0; bus.w_mem_ack = 1'b0;
    bus6.w_req = '0; bus6.w_mem_ack = 1'b1;

    // ---- table: single core 2, write then read burst
    tv.push_back(mk(1, 4'h0, 1, 4'h0, 0, 0, 0, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 4'h4, 1, 4'h4, 2, 0, 0, 16'h8000, 8, 0, 1));
    tv.push_back(mk(0, 4'h4, 1, 4'h4, 2, 1, 0, 16'h8000, 8, 0, 1));
    for (int i = 1; i <= 7; i++)
      tv.push_back(mk(0, 4'h4, 1, 4'h4, 2, 1, 0, 16'h8000 + 16'(i), 8, i == 7, 1));
    tv.push_back(mk(0, 4'h4, 1, 4'h0, 2, 0, 0, 16'h8007, 8, 0, 1));
    tv.push_back(mk(0, 4'h4, 1, 4'h4, 2, 0, 1, 16'h8008, 4, 0, 1));
    tv.push_back(mk(0, 4'h4, 1, 4'h4, 2, 1, 1, 16'h8008, 4, 0, 1));
    for (int i = 1; i <= 3; i++)
      tv.push_back(mk(0, 4'h4, 1, 4'h4, 2, 1, 1, 16'h8008 + 16'(i), 4, i == 3, 1));
    tv.push_back(mk(0, 4'h0, 1, 4'h0, 2, 0, 1, 16'h800B, 4, 0, 1));
    tv.push_back(mk(0, 4'h0, 1, 4'h0, 2, 0, 1, 16'h800B, 4, 0, 0));
    foreach (tv[r]) begin
      cycle(tv[r].rst, tv[r].req, tv[r].ack);
      check($sformatf("t1_grant_r%0d", r), 32'(bus.r_grant), 32'(tv[r].grant));
      check($sformatf("t1_sel_r%0d", r),   32'(bus.r_sel),   32'(tv[r].sel));
      check($sformatf("t1_valid_r%0d", r), 32'(bus.r_valid), 32'(tv[r].valid));
      check($sformatf("t1_rw_r%0d", r),    32'(bus.r_rw),    32'(tv[r].rw));
      check($sformatf("t1_addr_r%0d", r),  32'(bus.r_addr),  32'(tv[r].addr));
      check($sformatf("t1_burst_r%0d", r), 32'(bus.r_burst), 32'(tv[r].burst));
      check($sformatf("t1_last_r%0d", r),  32'(bus.r_last),  32'(tv[r].last));
      check($sformatf("t1_busy_r%0d", r),  32'(bus.r_busy),  32'(tv[r].busy));
    end

    // ---- all cores requesting: round-robin order and 2-cycle gaps
    cycle(1, 4'h0, 1);
    ngr = 0; zeros = 0; seen = 0; prev_g = '0;
    for (int k = 0; k < 200 && ngr < 6; k++) begin
      cycle(0, 4'hF, 1);
      if (bus.r_grant != 0 && prev_g == 0) begin
        check("t2_order", 32'(bus.r_sel), 32'(ngr % N));
        check("t2_rw",    32'(bus.r_rw),  32'(ngr >= N));
        if (ngr == N) check("t2_c0_read_addr", 32'(bus.r_addr), 32'h0008);
        ngr++;
      end
      prev_g = bus.r_grant;
      if (bus.r_valid) begin
        if (seen && zeros != 0) check("t2_gap", 32'(zeros), 32'd2);
        zeros = 0; seen = 1;
      end else if (seen) zeros++;
    end
    check("t2_grants_seen", 32'(ngr), 32'd6);

    // ---- stalled write burst: beats freeze on ack=0, none skipped or repeated
    cycle(1, 4'h0, 1);
    pat = '{1, 0, 0, 1, 1, 0, 1};
    acked.delete(); last_idx = -1;
    for (int k = 0; k < 100; k++) begin
      bit a;
      if (acked.size() == 8) break;
      a = pat[k % 7];
      if (bus.r_valid && a) begin
        acked.push_back(int'(bus.r_addr));
        if (bus.r_last) last_idx = acked.size() - 1;
      end
      cycle(0, 4'h1, a);
    end
    check("t3_beats", 32'(acked.size()), 32'd8);
    foreach (acked[i]) check("t3_addr_seq", 32'(acked[i]), 32'(i));
    check("t3_last_pos", 32'(last_idx), 32'd7);
    cycle(0, 4'h0, 1);
    check("t3_idle_busy", 32'(bus.r_busy), 32'd0);

    // ---- 6-bit address space: core 0 region wraps at 0x10
    cycle(1, 4'h0, 1);
    bus6.w_req = 4'h1;
    q6.delete();
    for (int k = 0; k < 200 && q6.size() < 24; k++) begin
      cycle(0, 4'h0, 1);
      if (bus6.r_valid) q6.push_back(int'(bus6.r_addr));
    end
    bus6.w_req = 4'h0;
    check("t4_beats", 32'(q6.size()), 32'd24);
    foreach (q6[i]) check("t4_wrap_addr", 32'(q6[i]), 32'(i % 16));

    // ---- reset on 4th beat of core 1's burst
    cycle(1, 4'h0, 1);
    got = 0;
    for (int k = 0; k < 50; k++) begin
      cycle(0, 4'h2, 1);
      if (bus.r_valid && bus.r_addr == 16'h4003) begin got = 1; break; end
    end
    check("t5_reached_beat4", 32'(got), 32'd1);
    cycle(1, 4'h2, 1);
    check("t5_valid", 32'(bus.r_valid), 32'd0);
    check("t5_grant", 32'(bus.r_grant), 32'd0);
    check("t5_busy",  32'(bus.r_busy),  32'd0);
    check("t5_addr",  32'(bus.r_addr),  32'd0);
    check("t5_last",  32'(bus.r_last),  32'd0);
    cycle(0, 4'h2, 1);
    check("t5_regrant", 32'(bus.r_grant), 32'h2);
    check("t5_rw",      32'(bus.r_rw),    32'd0);
    check("t5_addr0",   32'(bus.r_addr),  32'h4000);

    // ---- core 2 drops request mid-burst, core 0 arrives mid-burst
    cycle(1, 4'h0, 1);
    cycle(0, 4'h4, 1);
    cycle(0, 4'h4, 1);
    n2 = 0; got = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.r_grant == 4'h4 && bus.r_valid) n2++;
      cycle(0, 4'h1, 1);
      if (bus.r_grant != 0 && bus.r_grant != 4'h4) begin got = 1; break; end
    end
    check("t6_core2_beats", 32'(n2), 32'd8);
    check("t6_next_granted", 32'(got), 32'd1);
    check("t6_next_grant", 32'(bus.r_grant), 32'h1);
    check("t6_next_addr",  32'(bus.r_addr),  32'h0000);

    // ---- random traffic against the reference model
    cycle(1, 4'h0, 1);
    for (int k = 0; k < 3000; k++) begin
      bit [N-1:0] rq;
      lo = $urandom_range(0, 3);
      rq = N'($urandom) & N'($urandom);
      if (lo == 0) rq = N'($urandom);
      cycle($urandom_range(0, 399) == 0, rq, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
